// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared RX state encoding and bit-index width for the UART loader
package uart_loader_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
  localparam int BIT_IDX_W = 3;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-FF synchroniser, mid-bit sampling and stuck-low guard
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       rx,
  input  logic       clr,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err_pulse,
  output logic       busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  logic [1:0] sync;
  logic rx_s;
  rx_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [BIT_IDX_W-1:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  assign rx_s = sync[1];
  assign busy = state != IDLE;
  assign byte_data = shreg;
  always_ff @(posedge clk_100 or posedge rst)
    if (rst) begin
      sync  <= 2'b11;
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      sync  <= {sync[0], rx};
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  // START waits half a bit, after which every sample lands mid-bit
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n = idx;
    shreg_n = shreg;
    byte_valid = 1'b0;
    frame_err_pulse = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (!rx_s) state_n = START;
      end
      START:
        if (timer == HALF) begin
          timer_n = '0;
          idx_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (timer == LAST) begin
          timer_n = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n = idx + 1'b1;
          if (idx == '1) state_n = STOP;
        end
      STOP:
        if (timer == LAST) begin
          timer_n = '0;
          byte_valid = rx_s;
          frame_err_pulse = !rx_s;
          state_n = rx_s ? IDLE : WAIT_HI;
        end
      WAIT_HI: begin
        timer_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (clr) begin
      state_n = IDLE;
      timer_n = '0;
      byte_valid = 1'b0;
      frame_err_pulse = 1'b0;
    end
  end
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: assembles UART bytes into words and writes them to memory at incrementing addresses
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH = 65536,
  parameter int MSB_FIRST = 1,
  parameter logic [31:0] END_WORD = 32'hFFFF,
  localparam int DATA_W = 8 * WORD_BYTES
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              rx,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);
  logic [7:0] rx_byte;
  logic byte_valid, fe_pulse, en_q, rise, take, last, end_hit, cap_hit;
  logic [DATA_W-1:0] word, word_n;
  logic [1:0] byte_cnt;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_100         (clk_100),
    .rst             (rst),
    .rx              (rx),
    .clr             (!enable),
    .byte_data       (rx_byte),
    .byte_valid      (byte_valid),
    .frame_err_pulse (fe_pulse),
    .busy            (busy)
  );
  assign rise = enable & ~en_q;
  assign take = enable & byte_valid & ~done;
  assign last = byte_cnt == 2'(WORD_BYTES - 1);
  assign word_n = (MSB_FIRST != 0) ? (word << 8) | DATA_W'(rx_byte)
                                   : (word >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
  assign end_hit = 32'(mem_data) == END_WORD;
  assign cap_hit = ({1'b0, word_cnt} + 1'b1) == (ADDR_W + 1)'(DEPTH);
  // a framing error also drops the partial word so the stream resynchronises on word boundaries
  always_ff @(posedge clk_100 or posedge rst)
    if (rst) begin
      en_q      <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      word_cnt  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      word      <= '0;
      byte_cnt  <= '0;
    end else begin
      en_q   <= enable;
      mem_we <= take & last;
      if (mem_we) begin
        mem_addr <= mem_addr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
        done     <= end_hit | cap_hit;
      end
      if (fe_pulse & enable) frame_err <= 1'b1;
      if (take) begin
        word     <= last ? '0 : word_n;
        byte_cnt <= last ? '0 : byte_cnt + 1'b1;
        if (last) mem_data <= word_n;
      end
      if (fe_pulse | ~enable) begin
        word     <= '0;
        byte_cnt <= '0;
      end
      if (rise) begin
        mem_addr  <= BASE_ADDR;
        word_cnt  <= '0;
        done      <= 1'b0;
        frame_err <= 1'b0;
        word      <= '0;
        byte_cnt  <= '0;
      end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: scenario tasks plus randomized words checked against a queue-based model
module tb_uart_mem_loader;
  localparam int CPB = 16;
  localparam int LAT = 9 * CPB + CPB / 2 + 4;
  logic clk = 1'b0, rst = 1'b0, rx0 = 1'b1, rx1 = 1'b1, en0 = 1'b0, en1 = 1'b0;
  logic [15:0] addr0, data0, cnt0, addr1, data1, cnt1;
  logic we0, busy0, done0, fe0, we1, busy1, done1, fe1;
  int tests = 0, fails = 0;
  logic [31:0] wq0[$], wq1[$];
  always #5 clk = ~clk;
  uart_mem_loader #(.CLKS_PER_BIT(CPB)) dut0 (
    .clk_100(clk), .rst(rst), .rx(rx0), .enable(en0), .mem_addr(addr0), .mem_data(data0),
    .mem_we(we0), .word_cnt(cnt0), .busy(busy0), .done(done0), .frame_err(fe0));
  uart_mem_loader #(.CLKS_PER_BIT(CPB), .DEPTH(2), .MSB_FIRST(0)) dut1 (
    .clk_100(clk), .rst(rst), .rx(rx1), .enable(en1), .mem_addr(addr1), .mem_data(data1),
    .mem_we(we1), .word_cnt(cnt1), .busy(busy1), .done(done1), .frame_err(fe1));
  always @(negedge clk) begin
    if (we0) wq0.push_back({addr0, data0});
    if (we1) wq1.push_back({addr1, data1});
  end
  task automatic set_rx(input int w, input logic v);
    if (w == 0) rx0 = v; else rx1 = v;
  endtask
  task automatic send_byte(input int w, input logic [7:0] b, input logic stop);
    @(negedge clk); set_rx(w, 1'b0); repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin set_rx(w, b[i]); repeat (CPB) @(negedge clk); end
    set_rx(w, stop); repeat (CPB) @(negedge clk);
    set_rx(w, 1'b1); repeat (CPB) @(negedge clk);
  endtask
  task automatic arm(input int w);
    @(negedge clk);
    if (w == 0) en0 = 1'b0; else en1 = 1'b0;
    repeat (3) @(negedge clk);
    if (w == 0) en0 = 1'b1; else en1 = 1'b1;
    repeat (3) @(negedge clk);
    wq0.delete(); wq1.delete();
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (addr0 !== 16'h0) begin fails++; $display("FAIL reset_addr: got %h want 0000", addr0); end
    tests++; if (data0 !== 16'h0) begin fails++; $display("FAIL reset_data: got %h want 0000", data0); end
    tests++; if ({we0, busy0, done0, fe0} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {we0, busy0, done0, fe0}); end
    tests++; if (cnt0 !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0000", cnt0); end
    tests++; if ({we1, busy1, done1, fe1} !== 4'b0) begin fails++; $display("FAIL reset_flags1: got %b want 0000", {we1, busy1, done1, fe1}); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_word;
    int lat;
    arm(0);
    send_byte(0, 8'hE8, 1'b1);
    fork
      send_byte(0, 8'h12, 1'b1);
      begin
        lat = 0;
        @(negedge clk);
        while (!we0 && lat < 2000) begin @(posedge clk); #1; lat++; end
        tests++; if (lat !== LAT) begin fails++; $display("FAIL word_latency: got %0d cycles want %0d", lat, LAT); end
        tests++; if ({addr0, data0} !== {16'h0000, 16'hE812}) begin fails++; $display("FAIL word_write: got %h@%h want e812@0000", data0, addr0); end
      end
    join
    tests++; if (wq0.size() !== 1) begin fails++; $display("FAIL word_count_writes: got %0d want 1", wq0.size()); end
    tests++; if ({cnt0, addr0} !== {16'd1, 16'd1}) begin fails++; $display("FAIL word_cnt_addr: got cnt %h addr %h want 1 1", cnt0, addr0); end
  endtask
  task automatic test_end_word;
    logic [7:0] bs[6] = '{8'hE0, 8'h51, 8'hFF, 8'hFF, 8'h34, 8'h56};
    arm(0);
    foreach (bs[i]) send_byte(0, bs[i], 1'b1);
    tests++; if (wq0.size() !== 2) begin fails++; $display("FAIL end_writes: got %0d want 2", wq0.size()); end
    else begin
      tests++; if (wq0[0] !== {16'h0, 16'hE051}) begin fails++; $display("FAIL end_w0: got %h want 0000e051", wq0[0]); end
      tests++; if (wq0[1] !== {16'h1, 16'hFFFF}) begin fails++; $display("FAIL end_w1: got %h want 0001ffff", wq0[1]); end
    end
    tests++; if ({done0, cnt0} !== {1'b1, 16'd2}) begin fails++; $display("FAIL end_done: got done %b cnt %h want 1 2", done0, cnt0); end
  endtask
  task automatic test_frame_err;
    arm(0);
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'h66, 1'b0);
    repeat (CPB) @(negedge clk);
    tests++; if ({fe0, busy0} !== 2'b10) begin fails++; $display("FAIL frame_flag: got fe %b busy %b want 1 0", fe0, busy0); end
    tests++; if (wq0.size() !== 0) begin fails++; $display("FAIL frame_nowrite: got %0d writes want 0", wq0.size()); end
    send_byte(0, 8'hAB, 1'b1);
    send_byte(0, 8'hCD, 1'b1);
    tests++; if (wq0.size() !== 1 || wq0[0] !== {16'h0, 16'hABCD}) begin fails++; $display("FAIL frame_recover: got %0d writes first %h want 1 0000abcd", wq0.size(), wq0.size() ? wq0[0] : 32'hx); end
    tests++; if (fe0 !== 1'b1) begin fails++; $display("FAIL frame_sticky: got %b want 1", fe0); end
  endtask
  task automatic test_glitch;
    arm(0);
    @(negedge clk); rx0 = 1'b0;
    repeat (4) @(negedge clk); rx0 = 1'b1;
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b want 1", busy0); end
    repeat (2 * CPB) @(negedge clk);
    tests++; if ({busy0, fe0} !== 2'b00 || wq0.size() !== 0) begin fails++; $display("FAIL glitch_idle: got busy %b fe %b writes %0d want 0 0 0", busy0, fe0, wq0.size()); end
    send_byte(0, 8'h3C, 1'b1);
    send_byte(0, 8'h5A, 1'b1);
    tests++; if (wq0.size() !== 1 || wq0[0] !== {16'h0, 16'h3C5A}) begin fails++; $display("FAIL glitch_nophantom: got %0d writes want 00003c5a", wq0.size()); end
  endtask
  task automatic test_enable;
    arm(0);
    send_byte(0, 8'h77, 1'b1);
    @(negedge clk); en0 = 1'b0;
    repeat (4) @(negedge clk); en0 = 1'b1;
    fork
      send_byte(0, 8'h99, 1'b1);
      begin repeat (5 * CPB) @(negedge clk); en0 = 1'b0; end
    join
    en0 = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (wq0.size() !== 0) begin fails++; $display("FAIL enable_abort: got %0d writes want 0", wq0.size()); end
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    tests++; if (wq0.size() !== 1 || wq0[0] !== {16'h0, 16'h1122}) begin fails++; $display("FAIL enable_rearm: got %0d writes want 00001122", wq0.size()); end
    tests++; if (cnt0 !== 16'd1) begin fails++; $display("FAIL enable_cnt: got %h want 1", cnt0); end
  endtask
  task automatic test_random;
    logic [31:0] exp[$];
    logic [7:0] b0, b1;
    logic dn = 1'b0;
    int n = 24;
    arm(0);
    for (int i = 0; i < n; i++) begin
      b0 = 8'($urandom); b1 = 8'($urandom);
      if (i == n - 3) begin b0 = 8'hFF; b1 = 8'hFF; end
      if (!dn) exp.push_back({16'(i), b0, b1});
      if ({b0, b1} == 16'hFFFF) dn = 1'b1;
      send_byte(0, b0, 1'b1);
      send_byte(0, b1, 1'b1);
    end
    tests++; if (wq0.size() !== exp.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", wq0.size(), exp.size()); end
    else foreach (exp[i]) begin
      tests++; if (wq0[i] !== exp[i]) begin fails++; $display("FAIL rand_word%0d: got %h want %h", i, wq0[i], exp[i]); end
    end
    tests++; if ({done0, cnt0} !== {dn, 16'(exp.size())}) begin fails++; $display("FAIL rand_done: got done %b cnt %h want %b %h", done0, cnt0, dn, exp.size()); end
  endtask
  task automatic test_depth;
    arm(1);
    for (int i = 1; i <= 6; i++) send_byte(1, 8'(i), 1'b1);
    tests++; if (wq1.size() !== 2) begin fails++; $display("FAIL depth_writes: got %0d want 2", wq1.size()); end
    else begin
      tests++; if (wq1[0] !== {16'h0, 16'h0201} || wq1[1] !== {16'h1, 16'h0403}) begin fails++; $display("FAIL depth_data: got %h %h want 00000201 00010403", wq1[0], wq1[1]); end
    end
    tests++; if ({done1, cnt1} !== {1'b1, 16'd2}) begin fails++; $display("FAIL depth_done: got done %b cnt %h want 1 2", done1, cnt1); end
  endtask
  task automatic test_async_reset;
    arm(0);
    send_byte(0, 8'h01, 1'b1);
    fork
      send_byte(0, 8'hC3, 1'b1);
      begin
        repeat (4 * CPB) @(negedge clk);
        tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL areset_busy_before: got %b want 1", busy0); end
        #2 rst = 1'b1;
        #1;
        tests++; if ({busy0, we0, done0, fe0, addr0, data0, cnt0} !== 52'h0) begin fails++; $display("FAIL areset_outputs: got busy %b addr %h data %h cnt %h want all 0", busy0, addr0, data0, cnt0); end
        tests++; if ({done1, cnt1, addr1} !== 33'h0) begin fails++; $display("FAIL areset_dut1: got done %b cnt %h addr %h want 0", done1, cnt1, addr1); end
      end
    join
    @(negedge clk); rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    wq0.delete();
    send_byte(0, 8'h5A, 1'b1);
    send_byte(0, 8'hA5, 1'b1);
    tests++; if (wq0.size() !== 1 || wq0[0] !== {16'h0, 16'h5AA5}) begin fails++; $display("FAIL areset_newframe: got %0d writes want 00005aa5", wq0.size()); end
  endtask
  initial begin
    test_reset();
    test_word();
    test_end_word();
    test_frame_err();
    test_glitch();
    test_enable();
    test_random();
    test_depth();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
